envelope_activity_detector: RTL and testbench

- Sits directly downstream of the per-interval audio min/max stage and consumes one (max, min) pair per interval.
- Computes the peak-to-peak amplitude of each interval and classifies it as LOUD, QUIET or NORMAL against programmable thresholds.
- Runs a hysteresis FSM that decides onset/offset of audio activity.
- Queues onset/offset events, tagged with the interval index, in a small FIFO for the host/readout logic.

---
 rtl/audio_pkg.sv | 53 +++++
 rtl/sync_fifo_fwft.sv | 71 +++++++
 rtl/envelope_activity_detector.sv | 203 ++++++++++++++++++++
 tb/tb_envelope_activity_detector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg: shared widths, classification/FSM types and event record   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package audio_pkg;

    localparam int SAMPLE_W      = 32;
    localparam int P2P_W         = 33;
    localparam int EVT_IDX_MAX_W = 16;

    typedef enum logic [1:0] {
        CLS_QUIET  = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_LOUD   = 2'd2
    } class_t;

    typedef enum logic [0:0] {
        ST_SILENT = 1'b0,
        ST_ACTIVE = 1'b1
    } act_state_t;

    // Index field sized for the widest supported interval counter.
    typedef struct packed {
        logic                     onset;
        logic [EVT_IDX_MAX_W-1:0] index;
    } evt_t;

    function automatic class_t classify(input logic [P2P_W-1:0] p2p,
                                        input logic [P2P_W-1:0] hi,
                                        input logic [P2P_W-1:0] lo);
        class_t c;
        if (p2p >= hi)
            c = CLS_LOUD;
        else if (p2p < lo)
            c = CLS_QUIET;
        else
            c = CLS_NORMAL;
        return c;
    endfunction

    // An inverted pair (min above max) has no meaningful swing.
    function automatic logic [P2P_W-1:0] peak_to_peak(input logic [SAMPLE_W-1:0] mx,
                                                      input logic [SAMPLE_W-1:0] mn);
        logic [P2P_W-1:0] d;
        d = {mx[SAMPLE_W-1], mx} - {mn[SAMPLE_W-1], mn};
        if ($signed(mn) > $signed(mx))
            d = '0;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft: synchronous first-word-fall-through FIFO with count   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo_fwft #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        w_do_pop  = pop && (count_q != '0);
        w_do_push = push && ((count_q != CNT_W'(DEPTH)) || w_do_pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_do_pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (w_do_push && !w_do_pop)
            count_d = count_q + CNT_W'(1);
        else if (!w_do_push && w_do_pop)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid = (count_q != '0);
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/envelope_activity_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | envelope_activity_detector: p2p classification, hysteresis onset/     |
// | offset FSM and event FIFO. Optional ENV_PEAK_TRACK_EN adds peak       |
// | tracking outputs. IDX_W must not exceed audio_pkg::EVT_IDX_MAX_W.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module envelope_activity_detector
    import audio_pkg::*;
#(
    parameter int IDX_W      = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_max,
    input  logic [SAMPLE_W-1:0] in_min,
    input  logic [P2P_W-1:0]    thr_hi,
    input  logic [P2P_W-1:0]    thr_lo,
    input  logic [HOLD_W-1:0]   hold_len,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_onset,
    output logic [IDX_W-1:0]    evt_index,
`ifdef ENV_PEAK_TRACK_EN
    output logic [P2P_W-1:0]    peak_p2p,
    output logic [IDX_W-1:0]    peak_index,
`endif
    output logic                active
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               s1_valid_q, s1_valid_d;
    logic [P2P_W-1:0]   s1_p2p_q,   s1_p2p_d;
    logic [IDX_W-1:0]   s1_idx_q,   s1_idx_d;
    logic [IDX_W-1:0]   idx_cnt_q,  idx_cnt_d;
    act_state_t         state_q,    state_d;
    logic [HOLD_W-1:0]  cnt_q,      cnt_d;

    logic [CNT_W-1:0]   w_fifo_count;
    logic [CNT_W-1:0]   w_occ;
    logic               w_accept;
    logic               w_s2_go;
    class_t             w_cls;
    logic [HOLD_W-1:0]  w_eff_hold;
    logic [HOLD_W:0]    w_cnt_inc;
    logic               w_hold_met;
    logic               w_push;
    evt_t               w_push_evt;
    evt_t               w_head;
    logic               w_unused_head_idx;

    // Stage 1 occupancy reserves a FIFO slot so no event can be dropped.
    assign w_occ    = w_fifo_count + CNT_W'(s1_valid_q);
    assign in_ready = (w_occ < CNT_W'(FIFO_DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_s2_go  = s1_valid_q && !frame_start;

    assign w_cls      = classify(s1_p2p_q, thr_hi, thr_lo);
    assign w_eff_hold = (hold_len == '0) ? HOLD_W'(1) : hold_len;
    assign w_cnt_inc  = {1'b0, cnt_q} + (HOLD_W+1)'(1);
    assign w_hold_met = (w_cnt_inc >= {1'b0, w_eff_hold});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_cnt_d  = idx_cnt_q;
        s1_valid_d = 1'b0;
        s1_p2p_d   = s1_p2p_q;
        s1_idx_d   = s1_idx_q;
        w_push     = 1'b0;
        w_push_evt = '0;

        if (w_s2_go) begin
            w_push_evt.index = EVT_IDX_MAX_W'(s1_idx_q);
            case (state_q)
                ST_SILENT: begin
                    if (w_cls == CLS_LOUD) begin
                        if (w_hold_met) begin
                            state_d          = ST_ACTIVE;
                            cnt_d            = '0;
                            w_push           = 1'b1;
                            w_push_evt.onset = 1'b1;
                        end else begin
                            cnt_d = w_cnt_inc[HOLD_W-1:0];
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_cls == CLS_QUIET) begin
                        if (w_hold_met) begin
                            state_d = ST_SILENT;
                            cnt_d   = '0;
                            w_push  = 1'b1;
                        end else begin
                            cnt_d = w_cnt_inc[HOLD_W-1:0];
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = ST_SILENT;
            endcase
        end

        // frame_start wins over the interval still sitting in stage 1.
        if (frame_start) begin
            state_d   = ST_SILENT;
            cnt_d     = '0;
            idx_cnt_d = '0;
        end

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_p2p_d   = peak_to_peak(in_max, in_min);
            s1_idx_d   = frame_start ? '0 : idx_cnt_q;
            idx_cnt_d  = s1_idx_d + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_p2p_q   <= '0;
            s1_idx_q   <= '0;
            idx_cnt_q  <= '0;
            state_q    <= ST_SILENT;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p2p_q   <= s1_p2p_d;
            s1_idx_q   <= s1_idx_d;
            idx_cnt_q  <= idx_cnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_push_evt),
        .pop   (evt_ready),
        .valid (evt_valid),
        .dout  (w_head),
        .count (w_fifo_count)
    );

    assign evt_onset         = w_head.onset;
    assign evt_index         = w_head.index[IDX_W-1:0];
    assign w_unused_head_idx = ^w_head.index;
    assign active            = (state_q == ST_ACTIVE);

`ifdef ENV_PEAK_TRACK_EN
    logic [P2P_W-1:0] peak_p2p_q, peak_p2p_d;
    logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
    logic             peak_ld_q,  peak_ld_d;

    always_comb begin
        peak_p2p_d = peak_p2p_q;
        peak_idx_d = peak_idx_q;
        peak_ld_d  = peak_ld_q;
        if (w_s2_go && (!peak_ld_q || (s1_p2p_q > peak_p2p_q))) begin
            peak_p2p_d = s1_p2p_q;
            peak_idx_d = s1_idx_q;
            peak_ld_d  = 1'b1;
        end
        if (frame_start) begin
            peak_p2p_d = '0;
            peak_idx_d = '0;
            peak_ld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_p2p_q <= '0;
            peak_idx_q <= '0;
            peak_ld_q  <= 1'b0;
        end else begin
            peak_p2p_q <= peak_p2p_d;
            peak_idx_q <= peak_idx_d;
            peak_ld_q  <= peak_ld_d;
        end
    end

    assign peak_p2p   = peak_p2p_q;
    assign peak_index = peak_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_envelope_activity_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_envelope_activity_detector: directed + random bench with an        |
// | event-queue reference model. Rev 1.0                                  |
// +----------------------------------------------------------------------+
module tb_envelope_activity_detector;

    localparam int IDX_W      = 7;
    localparam int FIFO_DEPTH = 4;
    localparam int HOLD_W     = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_max;
    logic [31:0]       in_min;
    logic [32:0]       thr_hi;
    logic [32:0]       thr_lo;
    logic [HOLD_W-1:0] hold_len;
    logic              evt_valid;
    logic              evt_ready;
    logic              evt_onset;
    logic [IDX_W-1:0]  evt_index;
    logic              active;
`ifdef ENV_PEAK_TRACK_EN
    logic [32:0]       peak_p2p;
    logic [IDX_W-1:0]  peak_index;
`endif

    always #5 clk = ~clk;

    envelope_activity_detector #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .HOLD_W     (HOLD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_max      (in_max),
        .in_min      (in_min),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .hold_len    (hold_len),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_onset   (evt_onset),
        .evt_index   (evt_index),
`ifdef ENV_PEAK_TRACK_EN
        .peak_p2p    (peak_p2p),
        .peak_index  (peak_index),
`endif
        .active      (active)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending interval, event queue, activity decision.
    typedef struct { bit onset; int index; } mevt_t;
    mevt_t  mq[$];
    bit     m_active;
    int     m_cnt;
    int     m_idx;
    bit     m_s1v;
    longint m_s1p;
    int     m_s1i;
    longint m_peak;
    int     m_peak_i;
    bit     m_peak_ld;

    function automatic longint p2p_of(input logic [31:0] mx, input logic [31:0] mn);
        longint a;
        longint b;
        a = longint'($signed(mx));
        b = longint'($signed(mn));
        return (b > a) ? 64'd0 : a - b;
    endfunction

    always @(posedge clk) begin
        bit     rdy, acc, pop, pushd, loud, quiet;
        longint h;
        mevt_t  e;
        if (reset) begin
            mq.delete();
            m_active = 0; m_cnt = 0; m_idx = 0; m_s1v = 0; m_s1p = 0; m_s1i = 0;
            m_peak = 0; m_peak_i = 0; m_peak_ld = 0;
        end else begin
            rdy   = (mq.size() + int'(m_s1v)) < FIFO_DEPTH;
            acc   = in_valid && rdy;
            pop   = (mq.size() > 0) && evt_ready;
            pushd = 0;
            e.onset = 0;
            e.index = m_s1i;
            if (m_s1v && !frame_start) begin
                h     = (hold_len == 0) ? 1 : longint'(hold_len);
                loud  = m_s1p >= longint'(thr_hi);
                quiet = !loud && (m_s1p < longint'(thr_lo));
                if (!m_active) begin
                    if (loud) begin
                        m_cnt++;
                        if (m_cnt >= h) begin m_active = 1; m_cnt = 0; pushd = 1; e.onset = 1; end
                    end else m_cnt = 0;
                end else begin
                    if (quiet) begin
                        m_cnt++;
                        if (m_cnt >= h) begin m_active = 0; m_cnt = 0; pushd = 1; end
                    end else m_cnt = 0;
                end
                if (!m_peak_ld || m_s1p > m_peak) begin
                    m_peak = m_s1p; m_peak_i = m_s1i; m_peak_ld = 1;
                end
            end
            if (pop) void'(mq.pop_front());
            if (pushd) mq.push_back(e);
            if (frame_start) begin
                m_active = 0; m_cnt = 0; m_idx = 0;
                m_peak = 0; m_peak_i = 0; m_peak_ld = 0;
            end
            if (acc) begin
                m_s1v = 1;
                m_s1p = p2p_of(in_max, in_min);
                m_s1i = m_idx;
                m_idx = (m_idx + 1) % (1 << IDX_W);
            end else begin
                m_s1v = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_in_ready", 64'(in_ready), 64'((mq.size() + int'(m_s1v)) < FIFO_DEPTH));
            cmp("m_evt_valid", 64'(evt_valid), 64'(mq.size() > 0));
            cmp("m_evt_onset", 64'(evt_onset), (mq.size() > 0) ? 64'(mq[0].onset) : 64'd0);
            cmp("m_evt_index", 64'(evt_index), (mq.size() > 0) ? 64'(mq[0].index) : 64'd0);
            cmp("m_active", 64'(active), 64'(m_active));
`ifdef ENV_PEAK_TRACK_EN
            cmp("m_peak_p2p", 64'(peak_p2p), 64'(m_peak));
            cmp("m_peak_index", 64'(peak_index), 64'(m_peak_i));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int mx, input int mn, input bit fs);
        int n = 0;
        in_max   = mx;
        in_min   = mn;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        cmp("send_ready", 64'(in_ready), 64'd1);
        frame_start = fs;
        step();
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; in_valid = 1'b0; evt_ready = 1'b0;
        in_max = '0; in_min = '0; thr_hi = 33'd1000; thr_lo = 33'd100; hold_len = 8'd2;
        repeat (2) step();
        cmp("rst_in_ready", 64'(in_ready), 64'd1);
        cmp("rst_evt_valid", 64'(evt_valid), 64'd0);
        cmp("rst_evt_onset", 64'(evt_onset), 64'd0);
        cmp("rst_evt_index", 64'(evt_index), 64'd0);
        cmp("rst_active", 64'(active), 64'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        step();

        // Onset after two LOUD intervals
        send(600, -600, 0);
        send(700, -500, 0);
        cmp("t1_valid_early", 64'(evt_valid), 64'd0);
        cmp("t1_active_early", 64'(active), 64'd0);
        step();
        cmp("t1_valid", 64'(evt_valid), 64'd1);
        cmp("t1_onset", 64'(evt_onset), 64'd1);
        cmp("t1_index", 64'(evt_index), 64'd1);
        cmp("t1_active", 64'(active), 64'd1);
        cmp("t1_model_q", 64'(mq.size()), 64'd1);
        pop_one();
        cmp("t1_popped", 64'(evt_valid), 64'd0);

        // Offset with NORMAL resetting the hold count
        hold_len = 8'd3;
        send(25, -25, 0); send(25, -25, 0); send(250, -250, 0);
        send(25, -25, 0); send(25, -25, 0); send(25, -25, 0);
        cmp("t2_no_evt_yet", 64'(evt_valid), 64'd0);
        cmp("t2_still_active", 64'(active), 64'd1);
        step();
        cmp("t2_valid", 64'(evt_valid), 64'd1);
        cmp("t2_onset", 64'(evt_onset), 64'd0);
        cmp("t2_index", 64'(evt_index), 64'd7);
        cmp("t2_active", 64'(active), 64'd0);
        pop_one();

        // Full-range p2p and inverted pair
        thr_hi = 33'h0_FFFF_FFFF; hold_len = 8'd1;
        send(32'h7FFF_FFFF, 32'h8000_0000, 0);
        step();
        cmp("t3_big_onset", 64'(evt_onset), 64'd1);
        cmp("t3_big_index", 64'(evt_index), 64'd8);
        cmp("t3_big_model_p2p", 64'(m_peak_ld ? 64'd1 : 64'd0), 64'd1);
        pop_one();
        thr_lo = 33'd1;
        send(-10, 10, 0);
        step();
        cmp("t3_inv_valid", 64'(evt_valid), 64'd1);
        cmp("t3_inv_offset", 64'(evt_onset), 64'd0);
        cmp("t3_inv_index", 64'(evt_index), 64'd9);
        cmp("t3_inv_active", 64'(active), 64'd0);
        pop_one();

        // Backpressure: four events queue, input stalls, drain in order
        thr_hi = 33'd1000; thr_lo = 33'd100; hold_len = 8'd1;
        send(600, -600, 0); send(25, -25, 0); send(600, -600, 0); send(25, -25, 0);
        step();
        cmp("t4_full_ready", 64'(in_ready), 64'd0);
        cmp("t4_full_valid", 64'(evt_valid), 64'd1);
        in_max = 600; in_min = -600; in_valid = 1'b1;
        repeat (3) step();
        cmp("t4_stall_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmp("t4_drain_valid", 64'(evt_valid), 64'd1);
            cmp("t4_drain_onset", 64'(evt_onset), (k % 2 == 0) ? 64'd1 : 64'd0);
            cmp("t4_drain_index", 64'(evt_index), 64'(10 + k));
            step();
        end
        evt_ready = 1'b0;
        cmp("t4_empty", 64'(evt_valid), 64'd0);

        // frame_start coincident with an accepted pair
        frame_start = 1'b1; step(); frame_start = 1'b0;
        send(600, -600, 0);
        repeat (4) send(300, -300, 0);
        send(300, -300, 1);
        cmp("t5_fs_active", 64'(active), 64'd0);
        send(600, -600, 0);
        step();
        cmp("t5_q0_onset", 64'(evt_onset), 64'd1);
        cmp("t5_q0_index", 64'(evt_index), 64'd0);
        pop_one();
        cmp("t5_q1_valid", 64'(evt_valid), 64'd1);
        cmp("t5_q1_index", 64'(evt_index), 64'd1);
        cmp("t5_q1_active", 64'(active), 64'd1);
        pop_one();

`ifdef ENV_PEAK_TRACK_EN
        frame_start = 1'b1; step(); frame_start = 1'b0;
        thr_hi = 33'd5000; thr_lo = 33'd0;
        send(150, -150, 0); send(450, -450, 0); send(500, -400, 0); send(100, -100, 0);
        step();
        cmp("pk_p2p", 64'(peak_p2p), 64'd900);
        cmp("pk_index", 64'(peak_index), 64'd1);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        cmp("pk_clr_p2p", 64'(peak_p2p), 64'd0);
        cmp("pk_clr_index", 64'(peak_index), 64'd0);
`endif

        // Randomized traffic against the model
        thr_hi = 33'd1000; thr_lo = 33'd200; hold_len = 8'd2;
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 99) < 60);
            evt_ready   = ($urandom_range(0, 99) < 45);
            frame_start = ($urandom_range(0, 99) < 2);
            reset       = ($urandom_range(0, 999) < 4);
            if ($urandom_range(0, 9) == 0) begin
                in_max = $urandom();
                in_min = $urandom();
            end else begin
                in_max = 32'($signed($urandom_range(0, 2000)) - 1000);
                in_min = 32'($signed($urandom_range(0, 2000)) - 1000);
            end
            if ($urandom_range(0, 19) == 0) thr_hi = 33'($urandom_range(400, 1600));
            if ($urandom_range(0, 19) == 0) thr_lo = 33'($urandom_range(0, 400));
            if ($urandom_range(0, 19) == 0) hold_len = 8'($urandom_range(0, 3));
            step();
        end
        reset = 1'b0; frame_start = 1'b0; in_valid = 1'b0; evt_ready = 1'b1;
        repeat (10) step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
